led_select_ctrl: RTL and testbench
==================================

LED_SELECT_CTRL -- requirements
Module: led_select_ctrl

Interface
REQ-001 The block SHALL expose the following parameters.
- DEBOUNCE_CYCLES, default 12, number of consecutive stable samples required to accept a button level (20 ms at 600 Hz).
- AUTO_PERIOD, default 600, clk cycles between auto-scan steps (1 s at 600 Hz).
REQ-002 The block SHALL expose the following ports, clock and reset first.
- clk  input  1  single system clock, 600 Hz LED domain.
- rst_n  input  1  asynchronous, active-low reset.
- btn_next  input  1  raw, asynchronous, active-high "next LED" button.
- btn_prev  input  1  raw, asynchronous, active-high "previous LED" button.
- btn_auto  input  1  raw, asynchronous, active-high auto-scan toggle button.
- led_select  output  8  selected LED index 0..7 in bits [2:0]; bits [7:3] always 0; feeds the heartbeat LED driver.
- sel_changed  output  1  one-cycle pulse in the cycle led_select takes a new value.
- mode_auto  output  1  high while in AUTO state.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-004 The debouncer SHALL count cycles where the synchronized level differs from the debounced level, clear its count on any agreement, and flip the debounced level when the count reaches DEBOUNCE_CYCLES-1 while still differing.
REQ-005 A press SHALL be a one-cycle pulse on a debounced 0->1 transition; releases produce no event.
REQ-006 A raw press held stable SHALL update led_select on the (DEBOUNCE_CYCLES+3)th rising clk edge after the raw rise.
REQ-007 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no press.
REQ-008 The FSM SHALL have two states, MANUAL (reset state) and AUTO.
REQ-009 In MANUAL, a next press SHALL increment the index modulo 8 (7->0) and a prev press SHALL decrement it modulo 8 (0->7).
REQ-010 A next press and a prev press in the same cycle SHALL leave the index unchanged and assert no sel_changed.
REQ-011 An auto press SHALL toggle MANUAL<->AUTO; entering AUTO SHALL clear the auto counter to 0.
REQ-012 In AUTO, the auto counter SHALL count 0..AUTO_PERIOD-1; at AUTO_PERIOD-1 it SHALL wrap to 0 and the index SHALL increment modulo 8.
REQ-013 In AUTO, a next or prev press SHALL return the FSM to MANUAL and apply that step in the same cycle, taking priority over an auto step coinciding in that cycle.
REQ-014 An auto press coinciding with a next or prev press SHALL be resolved as follows: the mode toggle applies and the step is ignored.
REQ-015 sel_changed SHALL be a registered pulse, high for exactly the first cycle in which the new led_select is visible.
REQ-016 led_select SHALL never hold an index outside 0..7.

Reset
REQ-017 While rst_n=0, regardless of clk, the block SHALL hold: led_select=0, sel_changed=0, mode_auto=0, FSM=MANUAL, synchronizers, debounced levels and counters all 0.
REQ-018 Reset mid-debounce or mid-auto-period SHALL discard the partial count; after release, a button already held high SHALL count as one fresh press after full debounce.

Structure
REQ-019 The shared package/header SHALL hold NUM_LEDS=8, the FSM state encoding (MANUAL, AUTO), and the default values of DEBOUNCE_CYCLES and AUTO_PERIOD.
REQ-020 The synchronizer, debouncer and edge detector SHALL be one sub-module, btn_debounce, instantiated three times; the FSM and index logic SHALL live in led_select_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios.
- Reset, then btn_next held high for 20 cycles -> led_select 0->1 on edge 15 after the raw rise; sel_changed high for 1 cycle; no further change while held.
- btn_next pulse 8 cycles wide -> led_select stays 0; sel_changed never asserts.
- From index 0, a prev press -> 7; then a next press -> 0 (both wrap).
- btn_next and btn_prev pressed on the same cycle at index 3 -> index stays 3; sel_changed stays 0.
- btn_auto press -> mode_auto=1; led_select steps every 600 cycles 0->1->2; a next press at counter 599 -> mode_auto=0 and exactly one increment.
- rst_n pulsed low mid-auto at index 5 -> led_select=0, mode_auto=0 immediately without a clk edge.

Source files
------------

// File: rtl/led_select_ctrl_pkg.sv
// Shared constants, FSM encoding and index helpers for the LED selector.
package led_select_ctrl_pkg;

    localparam int unsigned NUM_LEDS                = 8;
    localparam int unsigned IDX_W                   = $clog2(NUM_LEDS);
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 12;
    localparam int unsigned AUTO_PERIOD_DEFAULT     = 600;

    typedef enum logic {
        StManual = 1'b0,
        StAuto   = 1'b1
    } state_e;

    // Increment an LED index, wrapping the last LED back to 0.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_LEDS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Decrement an LED index, wrapping 0 back to the last LED.
    function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] idx);
        return (idx == '0) ? IDX_W'(NUM_LEDS - 1) : idx - IDX_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchronizer, saturating-agreement debouncer
// and a registered one-cycle pulse on each accepted press (0->1).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count disagreeing samples; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_select_ctrl.sv
// LED selector: three debounced buttons drive a MANUAL/AUTO FSM that steps an
// index over the LEDs, with a registered pulse whenever the index changes.
module led_select_ctrl
    import led_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    output logic [7:0] led_select,
    output logic       sel_changed,
    output logic       mode_auto
);

    localparam int unsigned AutoCntW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AutoCntW-1:0] AutoCntLast = AutoCntW'(AUTO_PERIOD - 1);

    logic press_next, press_prev, press_auto;
    logic step_up, step_dn, step_any;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [AutoCntW-1:0] cnt_q, cnt_d;
    logic                changed_q, changed_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_next (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_next),
        .press  (press_next)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_prev (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_prev),
        .press  (press_prev)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_auto (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_auto),
        .press  (press_auto)
    );

    // Simultaneous next+prev cancel as a step but still count as user activity.
    assign step_up  = press_next & ~press_prev;
    assign step_dn  = press_prev & ~press_next;
    assign step_any = press_next | press_prev;

    // Next-state: mode toggle wins over steps; manual steps win over auto steps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (press_auto) begin
            state_d = (state_q == StManual) ? StAuto : StManual;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StManual: begin
                    cnt_d = '0;
                    if (step_up) begin
                        idx_d = idx_inc(idx_q);
                    end else if (step_dn) begin
                        idx_d = idx_dec(idx_q);
                    end
                end
                StAuto: begin
                    if (step_any) begin
                        state_d = StManual;
                        cnt_d   = '0;
                        if (step_up) begin
                            idx_d = idx_inc(idx_q);
                        end else if (step_dn) begin
                            idx_d = idx_dec(idx_q);
                        end
                    end else if (cnt_q == AutoCntLast) begin
                        cnt_d = '0;
                        idx_d = idx_inc(idx_q);
                    end else begin
                        cnt_d = cnt_q + AutoCntW'(1);
                    end
                end
                default: begin
                    state_d = StManual;
                    cnt_d   = '0;
                end
            endcase
        end
        changed_d = (idx_d != idx_q);
    end

    // FSM, index, auto counter and change-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StManual;
            idx_q     <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    assign led_select  = 8'(idx_q);
    assign sel_changed = changed_q;
    assign mode_auto   = (state_q == StAuto);

endmodule

// File: tb/tb_led_select_ctrl.sv
// Directed bench for led_select_ctrl: a vector table of button presses plus
// hand-timed sequences for latency, glitch, auto-scan and reset corners.
module tb_led_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       btn_auto = 1'b0;
    logic [7:0] led_select;
    logic       sel_changed;
    logic       mode_auto;

    int checks = 0;
    int failures = 0;

    logic [7:0] cur_sel = 8'd0;
    logic       cur_mode = 1'b0;

    typedef struct {
        logic       nx;
        logic       pv;
        logic       au;
        logic [7:0] exp_sel;
        logic       exp_mode;
        logic       exp_chg;
    } vec_t;

    vec_t vecs[10];

    led_select_ctrl #(
        .DEBOUNCE_CYCLES(12),
        .AUTO_PERIOD    (600)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_auto   (btn_auto),
        .led_select (led_select),
        .sel_changed(sel_changed),
        .mode_auto  (mode_auto)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Press the given buttons together; the result must appear on edge 15.
    task automatic press(input string name, input logic nx, input logic pv, input logic au,
                         input logic [7:0] exp_sel, input logic exp_mode, input logic exp_chg);
        @(negedge clk);
        btn_next = nx;
        btn_prev = pv;
        btn_auto = au;
        repeat (14) @(posedge clk);
        #1;
        check({name, "_pre_sel"}, led_select, cur_sel);
        check({name, "_pre_mode"}, mode_auto, cur_mode);
        @(posedge clk);
        #1;
        check({name, "_sel"}, led_select, exp_sel);
        check({name, "_mode"}, mode_auto, exp_mode);
        check({name, "_chg"}, sel_changed, exp_chg);
        @(posedge clk);
        #1;
        check({name, "_chg_off"}, sel_changed, 0);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_auto = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check({name, "_release_sel"}, led_select, exp_sel);
        cur_sel  = exp_sel;
        cur_mode = exp_mode;
    endtask

    initial begin
        logic bad;

        vecs[0] = '{nx: 1'b0, pv: 1'b1, au: 1'b0, exp_sel: 8'd0, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[1] = '{nx: 1'b0, pv: 1'b1, au: 1'b0, exp_sel: 8'd7, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[2] = '{nx: 1'b1, pv: 1'b0, au: 1'b0, exp_sel: 8'd0, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[3] = '{nx: 1'b1, pv: 1'b0, au: 1'b0, exp_sel: 8'd1, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[4] = '{nx: 1'b1, pv: 1'b0, au: 1'b0, exp_sel: 8'd2, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[5] = '{nx: 1'b1, pv: 1'b0, au: 1'b0, exp_sel: 8'd3, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[6] = '{nx: 1'b1, pv: 1'b1, au: 1'b0, exp_sel: 8'd3, exp_mode: 1'b0, exp_chg: 1'b0};
        vecs[7] = '{nx: 1'b0, pv: 1'b1, au: 1'b0, exp_sel: 8'd2, exp_mode: 1'b0, exp_chg: 1'b1};
        vecs[8] = '{nx: 1'b1, pv: 1'b0, au: 1'b1, exp_sel: 8'd2, exp_mode: 1'b1, exp_chg: 1'b0};
        vecs[9] = '{nx: 1'b0, pv: 1'b0, au: 1'b1, exp_sel: 8'd2, exp_mode: 1'b0, exp_chg: 1'b0};

        // Reset values before any clock edge.
        #3;
        check("rst_sel", led_select, 0);
        check("rst_chg", sel_changed, 0);
        check("rst_mode", mode_auto, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 8-cycle glitch on next: no press.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (8) @(negedge clk);
        btn_next = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (sel_changed !== 1'b0 || led_select !== 8'd0) bad = 1'b1;
        end
        check("glitch_no_press", bad, 0);

        // Next held for 20 cycles: one step on edge 15, nothing afterwards.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("hold_edge14_sel", led_select, 0);
        @(posedge clk);
        #1;
        check("hold_edge15_sel", led_select, 1);
        check("hold_edge15_chg", sel_changed, 1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (sel_changed !== 1'b0 || led_select !== 8'd1) bad = 1'b1;
        end
        btn_next = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (sel_changed !== 1'b0 || led_select !== 8'd1) bad = 1'b1;
        end
        check("hold_single_step", bad, 0);
        cur_sel = 8'd1;

        // Table of presses from index 1 in MANUAL.
        for (int i = 0; i < 10; i++) begin
            press($sformatf("vec%0d", i), vecs[i].nx, vecs[i].pv, vecs[i].au,
                  vecs[i].exp_sel, vecs[i].exp_mode, vecs[i].exp_chg);
        end

        // Auto scan from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst2_sel", led_select, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_sel  = 8'd0;
        cur_mode = 1'b0;
        // Entry edge E is edge 15 of this press; task returns at E+21.
        press("auto_on", 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        repeat (578) @(posedge clk);
        #1;
        check("auto_e599_sel", led_select, 0);
        @(posedge clk);
        #1;
        check("auto_e600_sel", led_select, 1);
        check("auto_e600_chg", sel_changed, 1);
        repeat (599) @(posedge clk);
        #1;
        check("auto_e1199_sel", led_select, 1);
        @(posedge clk);
        #1;
        check("auto_e1200_sel", led_select, 2);
        check("auto_mode_kept", mode_auto, 1);
        // Raw rise before edge E+1786 lands the press on edge E+1800 (counter 599).
        repeat (585) @(posedge clk);
        #1;
        btn_next = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("auto_next_pre_sel", led_select, 2);
        @(posedge clk);
        #1;
        check("auto_next_sel", led_select, 3);
        check("auto_next_mode", mode_auto, 0);
        check("auto_next_chg", sel_changed, 1);
        btn_next = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (sel_changed !== 1'b0 || led_select !== 8'd3 || mode_auto !== 1'b0) bad = 1'b1;
        end
        check("auto_next_single_step", bad, 0);
        cur_sel  = 8'd3;
        cur_mode = 1'b0;

        // Reset mid-auto at index 5, with next held across reset.
        press("to4", 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1);
        press("to5", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1);
        press("auto5", 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        btn_next = 1'b1;
        #1;
        check("async_rst_sel", led_select, 0);
        check("async_rst_mode", mode_auto, 0);
        check("async_rst_chg", sel_changed, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("held_rst_pre_sel", led_select, 0);
        @(posedge clk);
        #1;
        check("held_rst_sel", led_select, 1);
        check("held_rst_chg", sel_changed, 1);
        check("held_rst_mode", mode_auto, 0);
        btn_next = 1'b0;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
